// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared state, mode encodings and Gray helper for count_source
package count_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;

    // Callers truncate the result to their own width; the low bits stay valid.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/count_step.sv
// rtl/count_step.sv - next sequence index and wrap flag from idx and latched mode
module count_step
    import count_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] idx,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] idx_next,
    output logic             wrap
);

    always_comb begin
        if (mode == MODE_DOWN) begin
            idx_next = idx - CNT_W'(1);
            wrap     = (idx == '0);
        end else begin
            idx_next = idx + CNT_W'(1);
            wrap     = &idx;
        end
    end

endmodule

// File: rtl/count_source.sv
// rtl/count_source.sv - sequenced count/status producer; COUNT_SOURCE_GRAY_EN enables Gray output in mode 2
module count_source
    import count_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int BURST_LEN = 8,
    parameter int SETUP_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] start_val,
    input  logic [1:0]       mode,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             status,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [3:0] SETUP_T = 4'(SETUP_CYC);
    localparam logic [7:0] BURST_T = 8'(BURST_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       beat_q, beat_d;
    logic [3:0]       timer_q, timer_d;
    logic             status_q, status_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] step_idx;
    logic             step_wrap;

    count_step #(.CNT_W(CNT_W)) u_step (
        .idx      (idx_q),
        .mode     (mode_q),
        .idx_next (step_idx),
        .wrap     (step_wrap)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        beat_d   = beat_q;
        timer_d  = timer_q;
        status_d = status_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d    = start_val;
                    mode_d   = mode;
                    beat_d   = '0;
                    timer_d  = SETUP_T;
                    status_d = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (stop) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    beat_d   = '0;
                    status_d = 1'b0;
                end else if (timer_q <= 4'd1) begin
                    status_d = 1'b1;
                    state_d  = PRESENT;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            PRESENT: begin
                // stop beats ack: the handshake is dropped and no done is raised
                if (stop) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    beat_d   = '0;
                    status_d = 1'b0;
                end else if (ack) begin
                    beat_d   = beat_q + 8'd1;
                    status_d = 1'b0;
                    if (beat_q + 8'd1 == BURST_T) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = step_idx;
                        wrap_d  = step_wrap;
                        timer_d = SETUP_T;
                        state_d = SETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef COUNT_SOURCE_GRAY_EN
        count_d = (mode_d == MODE_GRAY) ? CNT_W'(bin2gray(32'(idx_d))) : idx_d;
`else
        count_d = idx_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            mode_q   <= MODE_UP;
            beat_q   <= '0;
            timer_q  <= '0;
            status_q <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            beat_q   <= beat_d;
            timer_q  <= timer_d;
            status_q <= status_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign count  = count_q;
    assign status = status_q;
    assign busy   = (state_q == SETUP) || (state_q == PRESENT);
    assign done   = done_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_count_source.sv
// tb/tb_count_source.sv - table-driven check of count_source (CNT_W=2, BURST_LEN=6, SETUP_CYC=1)
module tb_count_source;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] start_val = 2'b00;
    logic [1:0] mode = 2'b00;
    logic       ack = 1'b0;
    logic [1:0] count;
    logic       status, busy, done, wrap;

    int n_vec = 0;
    int n_bad = 0;

`ifdef COUNT_SOURCE_GRAY_EN
    localparam logic [1:0] G2 = 2'b11;
    localparam logic [1:0] G3 = 2'b10;
`else
    localparam logic [1:0] G2 = 2'b10;
    localparam logic [1:0] G3 = 2'b11;
`endif

    typedef struct {
        string      nm;
        logic       st, sp;
        logic [1:0] sv, md;
        logic       a;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    count_source #(.CNT_W(2), .BURST_LEN(6), .SETUP_CYC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .start_val (start_val),
        .mode      (mode),
        .ack       (ack),
        .count     (count),
        .status    (status),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic st, input logic sp, input logic [1:0] sv,
                       input logic [1:0] md, input logic a, input logic [1:0] ec,
                       input logic es, input logic eb, input logic ed, input logic ew);
        vec_t v;
        v.nm = nm; v.st = st; v.sp = sp; v.sv = sv; v.md = md; v.a = a;
        v.exp = {ec, es, eb, ed, ew};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = {count, status, busy, done, wrap};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {count,status,busy,done,wrap} got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic [1:0] sv,
                         input logic [1:0] md, input logic a);
        start = st; stop = sp; start_val = sv; mode = md; ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // up burst from 01: wrap at 11->00, done after the 6th ack
        add("up0",  1,0,2'b01,2'd0,1, 2'b01,0,1,0,0);
        add("up1",  0,0,2'b01,2'd0,1, 2'b01,1,1,0,0);
        add("up2",  0,0,2'b01,2'd0,1, 2'b10,0,1,0,0);
        add("up3",  0,0,2'b01,2'd0,1, 2'b10,1,1,0,0);
        add("up4",  0,0,2'b01,2'd0,1, 2'b11,0,1,0,0);
        add("up5",  0,0,2'b01,2'd0,1, 2'b11,1,1,0,0);
        add("up6",  0,0,2'b01,2'd0,1, 2'b00,0,1,0,1);
        add("up7",  0,0,2'b01,2'd0,1, 2'b00,1,1,0,0);
        add("up8",  0,0,2'b01,2'd0,1, 2'b01,0,1,0,0);
        add("up9",  0,0,2'b01,2'd0,1, 2'b01,1,1,0,0);
        add("up10", 0,0,2'b01,2'd0,1, 2'b10,0,1,0,0);
        add("up11", 0,0,2'b01,2'd0,1, 2'b10,1,1,0,0);
        add("up12", 0,0,2'b01,2'd0,1, 2'b10,0,0,1,0);
        add("up13", 0,0,2'b01,2'd0,0, 2'b10,0,0,0,0);
        // down with stall, then stop together with ack
        add("dn0",  1,0,2'b00,2'd1,0, 2'b00,0,1,0,0);
        add("dn1",  0,0,2'b00,2'd1,0, 2'b00,1,1,0,0);
        add("dn2",  0,0,2'b00,2'd1,0, 2'b00,1,1,0,0);
        add("dn3",  0,0,2'b00,2'd1,0, 2'b00,1,1,0,0);
        add("dn4",  0,0,2'b00,2'd1,0, 2'b00,1,1,0,0);
        add("dn5",  0,0,2'b00,2'd1,1, 2'b11,0,1,0,1);
        add("dn6",  0,0,2'b00,2'd1,0, 2'b11,1,1,0,0);
        add("ab0",  0,1,2'b00,2'd1,1, 2'b00,0,0,0,0);
        add("ab1",  0,0,2'b00,2'd1,0, 2'b00,0,0,0,0);
        // Gray (or plain up when Gray is compiled out), then stop in SETUP
        add("gr0",  1,0,2'b00,2'd2,1, 2'b00,0,1,0,0);
        add("gr1",  0,0,2'b00,2'd2,1, 2'b00,1,1,0,0);
        add("gr2",  0,0,2'b00,2'd2,1, 2'b01,0,1,0,0);
        add("gr3",  0,0,2'b00,2'd2,1, 2'b01,1,1,0,0);
        add("gr4",  0,0,2'b00,2'd2,1, G2,   0,1,0,0);
        add("gr5",  0,0,2'b00,2'd2,1, G2,   1,1,0,0);
        add("gr6",  0,0,2'b00,2'd2,1, G3,   0,1,0,0);
        add("gr7",  0,0,2'b00,2'd2,1, G3,   1,1,0,0);
        add("gr8",  0,0,2'b00,2'd2,1, 2'b00,0,1,0,1);
        add("gr9",  0,1,2'b00,2'd2,0, 2'b00,0,0,0,0);
        // start pulses while busy and in DONE are ignored
        add("ig0",  1,0,2'b10,2'd0,1, 2'b10,0,1,0,0);
        add("ig1",  1,0,2'b00,2'd1,1, 2'b10,1,1,0,0);
        add("ig2",  1,0,2'b00,2'd1,1, 2'b11,0,1,0,0);
        add("ig3",  1,0,2'b00,2'd1,1, 2'b11,1,1,0,0);
        add("ig4",  1,0,2'b00,2'd1,1, 2'b00,0,1,0,1);
        add("ig5",  1,0,2'b00,2'd1,1, 2'b00,1,1,0,0);
        add("ig6",  1,0,2'b00,2'd1,1, 2'b01,0,1,0,0);
        add("ig7",  1,0,2'b00,2'd1,1, 2'b01,1,1,0,0);
        add("ig8",  1,0,2'b00,2'd1,1, 2'b10,0,1,0,0);
        add("ig9",  1,0,2'b00,2'd1,1, 2'b10,1,1,0,0);
        add("ig10", 1,0,2'b00,2'd1,1, 2'b11,0,1,0,0);
        add("ig11", 1,0,2'b00,2'd1,1, 2'b11,1,1,0,0);
        add("ig12", 1,0,2'b00,2'd1,1, 2'b11,0,0,1,0);
        add("ig13", 1,0,2'b00,2'd1,1, 2'b11,0,0,0,0);
        add("ig14", 0,0,2'b00,2'd1,0, 2'b11,0,0,0,0);

        #2 rst_n = 1'b0;
        #1 chk("reset_state", 6'b00_0_0_0_0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;

        // reset asserted mid-run clears outputs without a clock edge
        drive(1, 0, 2'b11, 2'd0, 0);
        chk("rst_run_setup", 6'b11_0_1_0_0);
        drive(0, 0, 2'b11, 2'd0, 0);
        chk("rst_run_present", 6'b11_1_1_0_0);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 6'b00_0_0_0_0);
        @(negedge clk) rst_n = 1'b1;
        drive(1, 0, 2'b01, 2'd0, 0);
        chk("post_rst_start", 6'b01_0_1_0_0);
        drive(0, 0, 2'b01, 2'd0, 0);
        chk("post_rst_present", 6'b01_1_1_0_0);
        drive(0, 1, 2'b01, 2'd0, 0);
        chk("post_rst_stop", 6'b00_0_0_0_0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].sv, vecs[i].md, vecs[i].a);
            chk(vecs[i].nm, vecs[i].exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
